// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side handshake bundle for mem_port_arbiter.
// The master modport is the arbiter's view; slave is the caches and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_gnt;
   logic              ic_rvalid;
   logic [DATA_W-1:0] ic_rdata;

   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_gnt;
   logic              dc_ack;
   logic [DATA_W-1:0] dc_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              mem_err;

   modport master (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output ic_gnt, ic_rvalid, ic_rdata, dc_gnt, dc_ack, dc_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, busy, mem_err
   );

   modport slave (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  ic_gnt, ic_rvalid, ic_rdata, dc_gnt, dc_ack, dc_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, busy, mem_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache, one transaction in flight.
// Read: gnt 1 cycle after req, rvalid 3 cycles after; mem_ready stalls ISSUE; missing mem_rvalid times out to 0.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic                 clk,
   input logic                 reset,
   mem_port_arbiter_if.master  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;            // 1 = data cache
   logic              last_owner, last_owner_nxt;
   logic              pick_dc;
   logic [CNT_W-1:0]  cnt, cnt_nxt;

   logic              ic_gnt_q, ic_gnt_nxt, dc_gnt_q, dc_gnt_nxt;
   logic              ic_rvalid_q, ic_rvalid_nxt, dc_ack_q, dc_ack_nxt;
   logic              mem_req_q, mem_req_nxt, mem_we_q, mem_we_nxt;
   logic              busy_q, busy_nxt, mem_err_q, mem_err_nxt;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
   logic [DATA_W-1:0] ic_rdata_q, ic_rdata_nxt, dc_rdata_q, dc_rdata_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         cnt         <= '0;
         ic_gnt_q    <= 1'b0;
         dc_gnt_q    <= 1'b0;
         ic_rvalid_q <= 1'b0;
         dc_ack_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         last_owner  <= last_owner_nxt;
         cnt         <= cnt_nxt;
         ic_gnt_q    <= ic_gnt_nxt;
         dc_gnt_q    <= dc_gnt_nxt;
         ic_rvalid_q <= ic_rvalid_nxt;
         dc_ack_q    <= dc_ack_nxt;
         mem_req_q   <= mem_req_nxt;
         mem_we_q    <= mem_we_nxt;
         busy_q      <= busy_nxt;
         mem_err_q   <= mem_err_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_wdata_q <= mem_wdata_nxt;
         ic_rdata_q  <= ic_rdata_nxt;
         dc_rdata_q  <= dc_rdata_nxt;
      end
   end

   // Every output flop is loaded from its next-state value, so pulses line up with state entry.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      pick_dc        = 1'b0;
      cnt_nxt        = cnt;
      ic_gnt_nxt     = 1'b0;
      dc_gnt_nxt     = 1'b0;
      ic_rvalid_nxt  = 1'b0;
      dc_ack_nxt     = 1'b0;
      mem_we_nxt     = mem_we_q;
      mem_addr_nxt   = mem_addr_q;
      mem_wdata_nxt  = mem_wdata_q;
      mem_err_nxt    = mem_err_q;
      ic_rdata_nxt   = ic_rdata_q;
      dc_rdata_nxt   = dc_rdata_q;

      unique case (state)
         IDLE: begin
            if (bus.ic_req || bus.dc_req) begin
               pick_dc        = bus.dc_req && (!bus.ic_req || !last_owner);
               owner_nxt      = pick_dc;
               last_owner_nxt = pick_dc;
               mem_addr_nxt   = pick_dc ? bus.dc_addr : bus.ic_addr;
               mem_we_nxt     = pick_dc && bus.dc_we;
               mem_wdata_nxt  = pick_dc ? bus.dc_wdata : '0;
               ic_gnt_nxt     = !pick_dc;
               dc_gnt_nxt     = pick_dc;
               state_nxt      = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               if (mem_we_q) begin
                  dc_ack_nxt = 1'b1;
                  state_nxt  = RESP;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (bus.mem_rvalid || cnt == CNT_W'(TIMEOUT - 1)) begin
               // A late mem_rvalid on the final cycle still wins over the timeout.
               if (!bus.mem_rvalid) mem_err_nxt = 1'b1;
               if (owner) dc_rdata_nxt = bus.mem_rvalid ? bus.mem_rdata : '0;
               else       ic_rdata_nxt = bus.mem_rvalid ? bus.mem_rdata : '0;
               ic_rvalid_nxt = !owner;
               dc_ack_nxt    = owner;
               state_nxt     = RESP;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      mem_req_nxt = (state_nxt == ISSUE);
      busy_nxt    = (state_nxt != IDLE);
   end

   assign bus.ic_gnt    = ic_gnt_q;
   assign bus.dc_gnt    = dc_gnt_q;
   assign bus.ic_rvalid = ic_rvalid_q;
   assign bus.dc_ack    = dc_ack_q;
   assign bus.ic_rdata  = ic_rdata_q;
   assign bus.dc_rdata  = dc_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.mem_err   = mem_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ic_req     = 1'b0;
      bus.ic_addr    = '0;
      bus.dc_req     = 1'b0;
      bus.dc_we      = 1'b0;
      bus.dc_addr    = '0;
      bus.dc_wdata   = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   task automatic drain(output int cycles_left);
      cycles_left = 20;
      while (bus.busy && cycles_left > 0) begin
         tick();
         cycles_left--;
      end
   endtask

   initial begin
      int hi, gnt_cnt, rdy_cyc, ack_cyc, bad, ng, dbl, extra, waits, left, rv_seen;
      logic got_ack, prev_i, prev_d;
      logic order [4];

      idle_inputs();
      reset = 1'b0;
      #2;
      check_eq("reset_mem_req", bus.mem_req, 0);
      check_eq("reset_busy", bus.busy, 0);
      check_eq("reset_gnt", {bus.ic_gnt, bus.dc_gnt}, 0);
      check_eq("reset_resp", {bus.ic_rvalid, bus.dc_ack, bus.mem_err, bus.mem_we}, 0);
      check_eq("reset_data", {bus.ic_rdata, bus.dc_rdata}, 0);
      check_eq("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      tick();

      // Single IC read, minimum latency
      bus.ic_req  = 1'b1;
      bus.ic_addr = 32'h0000_0100;
      tick();
      check_eq("t1_ic_gnt", bus.ic_gnt, 1);
      check_eq("t1_mem_req", bus.mem_req, 1);
      check_eq("t1_mem_addr", bus.mem_addr, 32'h100);
      check_eq("t1_mem_we", bus.mem_we, 0);
      check_eq("t1_dc_gnt", bus.dc_gnt, 0);
      bus.ic_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      check_eq("t1_wait_gnt", bus.ic_gnt, 0);
      check_eq("t1_wait_req", {bus.mem_req, bus.busy}, 2'b01);
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      tick();
      check_eq("t1_ic_rvalid", bus.ic_rvalid, 1);
      check_eq("t1_ic_rdata", bus.ic_rdata, 32'hDEAD_BEEF);
      check_eq("t1_dc_quiet", {bus.dc_gnt, bus.dc_ack, bus.dc_rdata}, 0);
      bus.mem_rvalid = 1'b0;
      tick();
      check_eq("t1_rvalid_pulse", bus.ic_rvalid, 0);
      check_eq("t1_idle", bus.busy, 0);

      // mem_rvalid while idle is ignored
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555_5555;
      tick();
      bus.mem_rvalid = 1'b0;
      tick();
      check_eq("t6_no_resp", {bus.ic_rvalid, bus.dc_ack, bus.busy}, 0);
      check_eq("t6_ic_rdata", bus.ic_rdata, 32'hDEAD_BEEF);
      check_eq("t6_dc_rdata", bus.dc_rdata, 0);

      // DC write with mem_ready delayed 3 cycles
      bus.dc_req   = 1'b1;
      bus.dc_we    = 1'b1;
      bus.dc_addr  = 32'h40;
      bus.dc_wdata = 32'h1234;
      tick();
      bus.dc_req = 1'b0;
      hi = 0; gnt_cnt = 0; rdy_cyc = -1; ack_cyc = -1; bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.mem_req) begin
            hi++;
            if (!bus.mem_we || bus.mem_addr != 32'h40 || bus.mem_wdata != 32'h1234) bad++;
         end
         if (bus.dc_gnt) gnt_cnt++;
         if (bus.dc_ack) ack_cyc = i;
         if (bus.dc_rdata != 0) bad++;
         bus.mem_ready = (bus.mem_req && hi == 4);
         if (bus.mem_ready) rdy_cyc = i;
         tick();
      end
      bus.mem_ready = 1'b0;
      check_eq("t2_req_cycles", hi, 4);
      check_eq("t2_bus_values", bad, 0);
      check_eq("t2_gnt_pulses", gnt_cnt, 1);
      check_eq("t2_ack_after_ready", ack_cyc, rdy_cyc + 1);

      // Both requesters held: round-robin from reset
      reset = 1'b0;
      #2 reset = 1'b1;
      bus.ic_req     = 1'b1;
      bus.ic_addr    = 32'h200;
      bus.dc_req     = 1'b1;
      bus.dc_we      = 1'b0;
      bus.dc_addr    = 32'h300;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_F00D;
      ng = 0; dbl = 0; extra = 0; prev_i = 1'b0; prev_d = 1'b0;
      for (int i = 0; i < 4; i++) order[i] = 1'bx;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         tick();
         if ((bus.ic_gnt && prev_i) || (bus.dc_gnt && prev_d) || (bus.ic_gnt && bus.dc_gnt)) dbl++;
         prev_i = bus.ic_gnt;
         prev_d = bus.dc_gnt;
         if (bus.ic_gnt && ng < 4) begin order[ng] = 1'b0; ng++; end
         if (bus.dc_gnt && ng < 4) begin order[ng] = 1'b1; ng++; end
      end
      bus.ic_req = 1'b0;
      bus.dc_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.ic_gnt || bus.dc_gnt) extra++;
      end
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      check_eq("t3_grant_count", ng, 4);
      check_eq("t3_order0", order[0], 0);
      check_eq("t3_order1", order[1], 1);
      check_eq("t3_order2", order[2], 0);
      check_eq("t3_order3", order[3], 1);
      check_eq("t3_single_pulse", dbl, 0);
      check_eq("t3_no_extra_gnt", extra, 0);
      check_eq("t3_rdata", {bus.ic_rdata, bus.dc_rdata}, {32'h0BAD_F00D, 32'h0BAD_F00D});

      // DC read timeout
      bus.dc_req    = 1'b1;
      bus.dc_we     = 1'b0;
      bus.dc_addr   = 32'h80;
      bus.mem_ready = 1'b1;
      tick();
      check_eq("t4_dc_gnt", bus.dc_gnt, 1);
      bus.dc_req = 1'b0;
      waits = 0; got_ack = 1'b0;
      for (int i = 0; i < 20 && !got_ack; i++) begin
         tick();
         if (bus.dc_ack) got_ack = 1'b1;
         else if (bus.busy && !bus.mem_req) waits++;
      end
      bus.mem_ready = 1'b0;
      check_eq("t4_ack_seen", got_ack, 1);
      check_eq("t4_wait_cycles", waits, 4);
      check_eq("t4_dc_rdata", bus.dc_rdata, 0);
      check_eq("t4_mem_err", bus.mem_err, 1);
      tick();
      check_eq("t4_ack_pulse", bus.dc_ack, 0);
      check_eq("t4_err_sticky", bus.mem_err, 1);
      bus.ic_req  = 1'b1;
      bus.ic_addr = 32'h500;
      tick();
      bus.ic_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1357_2468;
      tick();
      bus.mem_rvalid = 1'b0;
      check_eq("t4_ic_rvalid", bus.ic_rvalid, 1);
      check_eq("t4_ic_rdata", bus.ic_rdata, 32'h1357_2468);
      check_eq("t4_err_still", bus.mem_err, 1);
      tick();

      // Reset during WAIT of an IC read
      bus.ic_req  = 1'b1;
      bus.ic_addr = 32'h600;
      tick();
      bus.ic_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check_eq("t5_in_wait", bus.busy, 1);
      reset = 1'b0;
      #1;
      check_eq("t5_drop", {bus.mem_req, bus.busy, bus.mem_err}, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777_7777;
      rv_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.mem_rvalid = 1'b0;
         if (bus.ic_rvalid || bus.busy) rv_seen++;
      end
      check_eq("t5_no_rvalid", rv_seen, 0);
      check_eq("t5_ic_rdata", bus.ic_rdata, 0);
      bus.ic_req = 1'b1;
      bus.dc_req = 1'b1;
      bus.dc_we  = 1'b1;
      tick();
      check_eq("t5_first_owner", {bus.ic_gnt, bus.dc_gnt}, 2'b10);
      bus.ic_req     = 1'b0;
      bus.dc_req     = 1'b0;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      drain(left);
      check_eq("t5_drain", left > 0, 1);
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing-memory interface between the instruction-cache refill path and the data-cache read/write path.
- Round-robin arbitration, one outstanding transaction at a time.
- Registered request/grant/response handshakes toward both caches, plus a memory-side ready/valid handshake with a response timeout.
- Sits between the instruction/data cache units and the backing memory in the memory system.

Parameters:
ADDR_W, 32, address width for both requesters and memory
DATA_W, 32, data width
TIMEOUT, 255, max cycles in WAIT for mem_rvalid before error completion (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ic_req  input  1  instruction-cache read request; held until ic_gnt
ic_addr  input  ADDR_W  instruction read address
ic_gnt  output  1  one-cycle pulse: ic request accepted
ic_rvalid  output  1  one-cycle pulse: ic_rdata valid
ic_rdata  output  DATA_W  instruction read data
dc_req  input  1  data-cache request; held until dc_gnt
dc_we  input  1  1 = write, 0 = read
dc_addr  input  ADDR_W  data address
dc_wdata  input  DATA_W  write data
dc_gnt  output  1  one-cycle pulse: dc request accepted
dc_ack  output  1  one-cycle pulse: read data valid or write accepted
dc_rdata  output  DATA_W  data read data
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  memory read data valid
mem_rdata  input  DATA_W  memory read data
busy  output  1  state != IDLE
mem_err  output  1  sticky: a read timed out

Behaviour:
- Reset (reset=0, async): state=IDLE, last_owner=DC (so IC wins the first tie), timeout counter=0. All outputs are 0: ic_gnt, ic_rvalid, ic_rdata, dc_gnt, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, mem_err.
- Reset mid-transaction: mem_req drops immediately. Pending transaction is discarded, with no gnt/rvalid/ack afterwards.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only here.
  - Only one requesting: that one wins.
  - Both requesting: the one that is not last_owner wins.
  - On a win: latch owner, addr, we (IC forces we=0), wdata; update last_owner; go to ISSUE.
- ISSUE:
  - mem_req=1, mem_addr/mem_we/mem_wdata driven from latched values.
  - Owner's gnt pulses in the first ISSUE cycle only.
  - Stay in ISSUE until mem_ready=1 is sampled.
  - Write + mem_ready: go to RESP (dc_ack next cycle).
  - Read + mem_ready: go to WAIT, counter cleared.
  - mem_rvalid during ISSUE is ignored.
- WAIT:
  - mem_req=0; counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata into the owner's rdata register and go to RESP.
  - Counter reaches TIMEOUT without mem_rvalid: owner rdata=0, mem_err<=1, go to RESP.
- RESP:
  - Owner's ic_rvalid or dc_ack pulses for one cycle; next state IDLE.
  - A new request can be sampled in the following IDLE cycle.
- Minimum read latency (mem_ready in first ISSUE cycle, mem_rvalid one cycle later): req seen at N, gnt+mem_req at N+1, WAIT at N+2 with mem_rvalid, rvalid pulse at N+3.
- Minimum write latency: req at N, gnt+mem_req at N+1 with mem_ready, dc_ack at N+2.
- ic_rdata/dc_rdata hold their value until the next completion for that port.
- mem_err is cleared only by reset.
- mem_rvalid in IDLE or RESP is ignored.
- Counter width is clog2(TIMEOUT+1); it never wraps, because it is cleared on WAIT entry.

Test Plan:
- Single IC read, mem_ready=1 at issue, mem_rvalid one cycle later with 0xDEADBEEF: ic_gnt at N+1, ic_rvalid at N+3 with ic_rdata=0xDEADBEEF. dc outputs stay 0 throughout.
- DC write to addr 0x40, data 0x1234, mem_ready delayed 3 cycles: mem_req high for exactly 4 cycles with mem_we=1, mem_addr=0x40, mem_wdata=0x1234. dc_ack 1 cycle after mem_ready. No dc_rdata change.
- ic_req and dc_req both held high for 4 transactions: grant order IC, DC, IC, DC after reset. Each gnt is a single-cycle pulse.
- DC read with mem_rvalid never asserted, TIMEOUT=4: dc_ack after 4 WAIT cycles with dc_rdata=0, mem_err=1 and staying 1. The next IC read completes normally.
- Assert reset in WAIT of an IC read, then release and pulse mem_rvalid: mem_req/busy drop at once, no ic_rvalid pulse, last_owner=DC restored.
- mem_rvalid pulsed while IDLE with no requests: no rvalid/ack, rdata registers unchanged.
